alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle controller that computes a 32x32 unsigned multiply (low 32 bits) using shift-and-add.
- Time-shares the existing 32-bit single-cycle ALU: it drives the ALU operands, control and shift amount, then captures the ALU result each cycle.
- Sits beside the ALU in the execute stage. The multiply path is muxed onto the ALU inputs while busy is high.

Parameters:
- WIDTH, 32, operand and product width; only 32 is supported.
- MAX_ITER, 32, maximum number of multiplier bits processed.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- op_a  input  32  multiplicand; latched on accepted start
- op_b  input  32  multiplier; latched on accepted start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; product is valid in this cycle
- product  output  32  low 32 bits of op_a*op_b; held until the next accepted start
- alu_a  output  32  ALU operand a
- alu_b  output  32  ALU operand b
- alu_shamt  output  6  ALU shift amount
- alu_control  output  3  ALU opcode: 010 = ADD, 101 = SLL (b << shamt)
- alu_result  input  32  combinational ALU output for the current drive

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset:
  - state = IDLE; busy = 0, done = 0, product = 0.
  - Internal acc, mcand, mplier and cnt (6-bit) all = 0.
  - Reset mid-operation aborts the operation. No done is produced and product is cleared to 0.
- State machine: IDLE, STEP, ADD, SHIFT, DONE.
- IDLE:
  - ALU drive is alu_control = 010, alu_a = 0, alu_b = 0, alu_shamt = 0.
  - If start = 1: acc <= 0, mcand <= op_a, mplier <= op_b, cnt <= 0; go to STEP.
- STEP (no ALU use; drive as in IDLE):
  - If mplier == 0 or cnt == MAX_ITER: product <= acc; go to DONE.
  - Else if mplier[0] = 1: go to ADD.
  - Else: go to SHIFT.
- ADD:
  - Drive alu_control = 010, alu_a = acc, alu_b = mcand.
  - acc <= alu_result (wraps modulo 2^32; carry discarded). Go to SHIFT.
- SHIFT:
  - Drive alu_control = 101, alu_b = mcand, alu_shamt = 1, alu_a = 0.
  - mcand <= alu_result; mplier <= mplier >> 1 (zero fill); cnt <= cnt + 1. Go to STEP.
- DONE: done = 1 for exactly this one cycle; busy = 1; go to IDLE.
- Output decode: done and busy are decoded from state, with no combinational path from start.
- Start handling:
  - start is ignored in every non-IDLE state, including DONE. There is no queuing.
  - A start held high continuously is re-accepted in the IDLE cycle that follows DONE.
- Operand stability: op_a and op_b may change freely after the accepting edge.
- Latency:
  - Let E0 be the edge that accepts start. done is high in the cycle after edge E0+N.
  - N = 1 + sum over processed bits of (2 + bit value).
  - Processed bits = index of the highest set bit of op_b, plus 1 (0 bits if op_b = 0).
  - Range: N = 1 (op_b = 0) to N = 97 (op_b = 0xFFFFFFFF).
- Early termination: multiplier zero-detection stops the iteration as soon as mplier == 0. The cnt guard bounds the operation at 32 iterations.
- Overflow: only the low 32 bits are kept. There is no overflow flag.

Test Plan:
- reset, then op_a = 3, op_b = 5, start pulse -> done after edge E0+9; product = 15; busy high from E0+1 through the done cycle; ALU sees control 010 exactly twice and 101 exactly three times.
- op_a = 0x12345678, op_b = 0, start -> done after E0+1; product = 0; the ALU is never driven with 010 using nonzero operands.
- op_a = 0xFFFFFFFF, op_b = 0xFFFFFFFF -> done after E0+97; product = 0x00000001; cnt guard is not exceeded.
- op_a = 0x00010000, op_b = 0x00010000 -> done after E0+36; product = 0x00000000 (wrap).
- start pulsed again at E0+3 with different operands while busy (op_a = 7, op_b = 6 first) -> second request ignored; product = 42; exactly one done pulse.
- reset asserted at E0+5 during 7*6 -> next cycle busy = 0, done = 0, product = 0; done never pulses; a new start (2*2) then yields product = 4.

Source files
------------

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Sequential 32x32 unsigned multiply (low 32 bits of the product). It uses
// shift-and-add and borrows the execute-stage ALU for every add and shift,
// so this block holds no adder or shifter of its own.
//
// State table:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; the ALU is driven with ADD 0+0
//   S_STEP  | tests the multiplier: finish, add, or shift only
//   S_ADD   | acc <= acc + mcand on the ALU
//   S_SHIFT | mcand <= mcand << 1 on the ALU; mplier >>= 1; cnt++
//   S_DONE  | done pulse; the product is valid
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   start, op_a, op_b    multiply request and operands, sampled only in IDLE
//   busy, done, product  status and result; product holds until overwritten
//   alu_a, alu_b,
//   alu_shamt,
//   alu_control          drive to the shared ALU (010 = ADD, 101 = SLL)
//   alu_result           combinational result from the shared ALU
module alu_mul_seq #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [5:0]       alu_shamt,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [5:0] CNT_MAX = 6'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [5:0]       cnt;
    logic             finish;

    // Stop early once no multiplier bits remain. The count guard bounds the
    // operation at MAX_ITER iterations.
    assign finish = (mplier == '0) || (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        cnt    <= '0;
                    end
                end
                S_STEP: begin
                    if (finish) product <= acc;
                end
                S_ADD: begin
                    acc <= alu_result;
                end
                S_SHIFT: begin
                    mcand  <= alu_result;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        alu_control = ALU_ADD;
        alu_a       = '0;
        alu_b       = '0;
        alu_shamt   = '0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_STEP;
            end
            S_STEP: begin
                if (finish)         state_nxt = S_DONE;
                else if (mplier[0]) state_nxt = S_ADD;
                else                state_nxt = S_SHIFT;
            end
            S_ADD: begin
                alu_a     = acc;
                alu_b     = mcand;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                alu_control = ALU_SLL;
                alu_b       = mcand;
                alu_shamt   = 6'd1;
                state_nxt   = S_STEP;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] product;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [5:0]  alu_shamt;
    logic [2:0]  alu_control;

    alu_mul_seq #(.WIDTH(32), .MAX_ITER(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_shamt   (alu_shamt),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared single-cycle ALU.
    always_comb begin
        case (alu_control)
            3'b010:  alu_result = alu_a + alu_b;
            3'b101:  alu_result = alu_b << alu_shamt;
            default: alu_result = 32'h0;
        endcase
    end

    typedef struct {
        logic [31:0] prod;
        int          lat;
        int          e0;
        int          n_add;
        int          n_sll;
        bit          chk_alu;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   add_cnt = 0;
    int   sll_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: the product is plain arithmetic. The processed multiplier bits
    // run up to the highest set bit; each costs two cycles, plus one more when
    // the bit is set, and the final test-and-finish costs one cycle.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   bits;
        logic [63:0] full;
        bits = 0;
        for (int i = 0; i < 32; i++) if (b[i]) bits = i + 1;
        full      = 64'(a) * 64'(b);
        e.prod    = full[31:0];
        e.n_sll   = bits;
        e.n_add   = $countones(b);
        e.lat     = 1 + 2 * bits + e.n_add;
        e.e0      = 0;
        // With op_a odd, the shifted multiplicand never becomes zero, so every
        // add has a nonzero operand and can be counted.
        e.chk_alu = a[0] || (b == 32'h0);
        return e;
    endfunction

    // Monitor: consumes the scoreboard whenever the DUT presents done.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            add_cnt = 0;
            sll_cnt = 0;
        end else begin
            if (busy && !done) begin
                if (alu_control == 3'b101) begin
                    sll_cnt++;
                    check("sll_alu_a", 64'(alu_a), 64'h0);
                    check("sll_shamt", 64'(alu_shamt), 64'h1);
                end else if (alu_control == 3'b010 && (alu_a != 0 || alu_b != 0)) begin
                    add_cnt++;
                end
            end
            if (done) begin
                check("busy_in_done", 64'(busy), 64'h1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done required=no_done product=%0h", product);
                end else begin
                    e = sb.pop_front();
                    check("product", 64'(product), 64'(e.prod));
                    check("latency", 64'(cyc - e.e0), 64'(e.lat));
                    if (e.chk_alu) begin
                        check("alu_add_count", 64'(add_cnt), 64'(e.n_add));
                        check("alu_sll_count", 64'(sll_cnt), 64'(e.n_sll));
                    end
                end
                add_cnt = 0;
                sll_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit expect_done);
        exp_t e;
        int   t;
        @(negedge clk);
        t = 0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        if (expect_done) begin
            e    = model(a, b);
            e.e0 = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=pending_%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1;
        start = 1'b0;
        op_a  = 32'h0;
        op_b  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_product", 64'(product), 64'h0);
        check("rst_alu_ctl", 64'(alu_control), 64'h2);
        check("rst_alu_ops", {alu_a, alu_b}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        issue(32'd3, 32'd5, 1'b1);              drain();
        issue(32'h12345678, 32'h0, 1'b1);       drain();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); drain();
        issue(32'h00010000, 32'h00010000, 1'b1); drain();

        // A second request while busy must be dropped.
        issue(32'd7, 32'd6, 1'b1);
        repeat (2) @(negedge clk);
        @(negedge clk);
        op_a  = 32'd9;
        op_b  = 32'd11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // Reset in the middle of an operation aborts it and clears the product.
        issue(32'd7, 32'd6, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_done", 64'(done), 64'h0);
        check("abort_product", 64'(product), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        issue(32'd2, 32'd2, 1'b1); drain();

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            issue(ra, rb, 1'b1);
            drain();
        end

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
